regfile_mp_sb: RTL

- Parametrised multi-port integer register file with a built-in scoreboard, for the scalar core and the vector coprocessor's scalar-operand path.
- Supplies NUM_RD combinational read ports and NUM_WR synchronous write ports.
- Write-to-read bypass is selectable by parameter.
- Per-register busy bits support a pipelined issue stage: a register is reserved at issue and released at writeback, with a flush that clears all reservations.

---
 rtl/regfile_mp_sb_pkg.sv | 12 +
 rtl/regfile_scoreboard.sv | 79 +++++++
 rtl/regfile_mp_sb.sv | 101 ++++++++++
 3 files changed

// File: rtl/regfile_mp_sb_pkg.sv
// Shared constants for the multi-port register file and its scoreboard.
// WORD_WIDTH     : default register width
// REGFILE_SIZE   : default register count (power of two)
// REGFILE_BITS   : address width matching REGFILE_SIZE
// DEF_NUM_RD/WR  : default read/write port counts
package regfile_mp_sb_pkg;
    localparam int WORD_WIDTH   = 32;
    localparam int REGFILE_SIZE = 32;
    localparam int REGFILE_BITS = $clog2(REGFILE_SIZE);
    localparam int DEF_NUM_RD   = 4;
    localparam int DEF_NUM_WR   = 2;
endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard for the register file.
// Ports:
//   clk, nrst          clock, synchronous active-low reset
//   wr_en/wr_addr      writeback ports; a write releases its destination
//   rsv_en/rsv_addr    reservation request from the issue stage
//   flush              clears every reservation
//   rsv_ready          reservation can be accepted this cycle
//   busy_vec           current busy bit of every register
module regfile_scoreboard
    import regfile_mp_sb_pkg::*;
#(
    parameter int NUM_REGS = REGFILE_SIZE,
    parameter int NUM_WR   = DEF_NUM_WR,
    parameter bit ZERO_REG = 1'b1,
    localparam int AW      = $clog2(NUM_REGS)
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic [NUM_WR-1:0]    wr_en,
    input  logic [NUM_WR*AW-1:0] wr_addr,
    input  logic                 rsv_en,
    input  logic [AW-1:0]        rsv_addr,
    input  logic                 flush,
    output logic                 rsv_ready,
    output logic [NUM_REGS-1:0]  busy_vec
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] busy_next;
    logic [NUM_REGS-1:0] wr_hit;
    logic                rsv_acc;

    // Decode which registers are being written back this cycle.
    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < NUM_WR; k++) begin
            if (wr_en[k]) begin
                wr_hit[wr_addr[k*AW +: AW]] = 1'b1;
            end
        end
    end

    // A busy destination may be re-reserved only when its producer
    // retires in the same cycle; otherwise the issuer stalls (WAW).
    always_comb begin
        rsv_ready = !busy[rsv_addr] || wr_hit[rsv_addr] ||
                    (ZERO_REG && (rsv_addr == '0));
        rsv_acc   = rsv_en && rsv_ready && !flush;
    end

    // Priority: flush, then reservation, then write release, then hold.
    always_comb begin
        busy_next = busy;
        for (int r = 0; r < NUM_REGS; r++) begin
            if (flush) begin
                busy_next[r] = 1'b0;
            end else if (rsv_acc && (rsv_addr == AW'(r))) begin
                busy_next[r] = 1'b1;
            end else if (wr_hit[r]) begin
                busy_next[r] = 1'b0;
            end
        end
        if (ZERO_REG) begin
            busy_next[0] = 1'b0;
        end
    end

    // Busy-bit state register.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    assign busy_vec = busy;

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with built-in busy scoreboard.
// Ports:
//   clk, nrst          clock, synchronous active-low reset
//   rd_addr/rd_data    NUM_RD combinational read ports (packed)
//   rd_busy            operand on read port i is still pending
//   wr_en/wr_addr/     NUM_WR synchronous write ports (packed);
//   wr_data            the highest port index wins on collisions
//   rsv_en/rsv_addr    destination reservation at issue
//   rsv_ready          reservation can be accepted this cycle
//   flush              clears all busy bits
//   busy_vec           raw scoreboard state
module regfile_mp_sb
    import regfile_mp_sb_pkg::*;
#(
    parameter int WORD_WIDTH = regfile_mp_sb_pkg::WORD_WIDTH,
    parameter int NUM_REGS   = REGFILE_SIZE,
    parameter int NUM_RD     = DEF_NUM_RD,
    parameter int NUM_WR     = DEF_NUM_WR,
    parameter bit BYPASS     = 1'b1,
    parameter bit ZERO_REG   = 1'b1,
    localparam int AW        = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [NUM_RD*AW-1:0]         rd_addr,
    output logic [NUM_RD*WORD_WIDTH-1:0] rd_data,
    output logic [NUM_RD-1:0]            rd_busy,
    input  logic [NUM_WR-1:0]            wr_en,
    input  logic [NUM_WR*AW-1:0]         wr_addr,
    input  logic [NUM_WR*WORD_WIDTH-1:0] wr_data,
    input  logic                         rsv_en,
    input  logic [AW-1:0]                rsv_addr,
    output logic                         rsv_ready,
    input  logic                         flush,
    output logic [NUM_REGS-1:0]          busy_vec
);

    logic [WORD_WIDTH-1:0] mem [NUM_REGS];

    // Storage update; ports are applied in ascending order so the last
    // non-blocking assignment (highest port) wins on an address clash.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem[r] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && !(ZERO_REG && (wr_addr[k*AW +: AW] == '0))) begin
                    mem[wr_addr[k*AW +: AW]] <= wr_data[k*WORD_WIDTH +: WORD_WIDTH];
                end
            end
        end
    end

    // Read muxes with optional same-cycle forwarding. A forwarded write
    // also hides the busy bit, since the operand is available right now.
    always_comb begin
        logic [AW-1:0]         addr;
        logic [WORD_WIDTH-1:0] val;
        logic                  hit;
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            addr = rd_addr[i*AW +: AW];
            val  = mem[addr];
            hit  = 1'b0;
            for (int k = 0; k < NUM_WR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] == addr) &&
                    !(ZERO_REG && (addr == '0))) begin
                    hit = 1'b1;
                    if (BYPASS) begin
                        val = wr_data[k*WORD_WIDTH +: WORD_WIDTH];
                    end
                end
            end
            if (ZERO_REG && (addr == '0)) begin
                val = '0;
            end
            rd_data[i*WORD_WIDTH +: WORD_WIDTH] = val;
            rd_busy[i] = busy_vec[addr] && !(BYPASS && hit);
        end
    end

    regfile_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .NUM_WR   (NUM_WR),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk       (clk),
        .nrst      (nrst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .flush     (flush),
        .rsv_ready (rsv_ready),
        .busy_vec  (busy_vec)
    );

endmodule
